// File: rtl/btn_gesture_multi.sv
// btn_gesture_multi
// Multi-channel push-button gesture front end. Each channel synchronises and
// debounces its raw pin, then classifies short presses, long presses, and
// counts presses inside a window that opens after a long press is released.
// All timing is derived from one shared tick divider.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   btn_raw      raw button pins (asynchronous to clk), polarity set by ACTIVE_LOW
//   btn_level    debounced pressed state per channel, 1 = pressed
//   short_pulse  1-cycle pulse when a short press is released
//   long_pulse   1-cycle pulse when a hold reaches LONG_TICKS
//   cnt_valid    1-cycle pulse when a press-count window closes
//   press_cnt    per-channel count, channel i at [i*CNT_W +: CNT_W], held until
//                the next report
//
// Per-channel FSM:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for a debounced press
//   S_HOLD   | button held, hold timer running toward LONG_TICKS
//   S_ARMED  | long press seen, waiting for its release
//   S_WINDOW | counting presses until the window timer expires
//   S_REPORT | publish the count and pulse cnt_valid

module btn_gesture_multi #(
  parameter int N_BTN          = 4,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 3000,
  parameter int WINDOW_TICKS   = 5000,
  parameter int CNT_W          = 4,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_BTN-1:0]       btn_raw,
  output logic [N_BTN-1:0]       btn_level,
  output logic [N_BTN-1:0]       short_pulse,
  output logic [N_BTN-1:0]       long_pulse,
  output logic [N_BTN-1:0]       cnt_valid,
  output logic [N_BTN*CNT_W-1:0] press_cnt
);

  localparam int TMR_MAX = (LONG_TICKS > WINDOW_TICKS) ? LONG_TICKS : WINDOW_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W    = $clog2(DEBOUNCE_TICKS + 1);

  // Raw pin level that means "released", used as the synchroniser reset value.
  localparam logic [N_BTN-1:0] REL_RAW = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ARMED,
    S_WINDOW,
    S_REPORT
  } state_t;

  // ---------------------------------------------------------------------------
  // Shared tick divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser and polarity normalisation (pressed = 1)
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] sync_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= REL_RAW;
      sync2 <= REL_RAW;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign sync_lvl = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // ---------------------------------------------------------------------------
  // Per-channel debounce and gesture FSM
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [DB_W-1:0]  db_cnt;
    logic             lvl_q;
    logic             db_accept;
    logic             press_edge;
    logic             rel_edge;

    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] rpt_q;
    logic             short_d;
    logic             long_d;
    logic             valid_d;
    logic             short_q;
    logic             long_q;
    logic             valid_q;
    logic             hold_expire;
    logic             win_expire;

    // The new level is accepted on the tick that completes the stability run.
    // The edge strobes fire in that same tick cycle, so they line up with the
    // hold/window timer matches and the boundary cases can coincide.
    assign db_accept  = tick && (sync_lvl[i] != lvl_q) &&
                        (db_cnt == DB_W'(DEBOUNCE_TICKS - 1));
    assign press_edge = db_accept && !lvl_q;
    assign rel_edge   = db_accept &&  lvl_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt <= '0;
        lvl_q  <= 1'b0;
      end else if (sync_lvl[i] == lvl_q) begin
        db_cnt <= '0;
      end else if (db_accept) begin
        db_cnt <= '0;
        lvl_q  <= sync_lvl[i];
      end else if (tick) begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    assign hold_expire = tick && (tmr_q == TMR_W'(LONG_TICKS - 1));
    assign win_expire  = tick && (tmr_q == TMR_W'(WINDOW_TICKS - 1));

    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      valid_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (press_edge) begin
            state_d = S_HOLD;
            tmr_d   = '0;
          end
        end
        S_HOLD: begin
          if (tick) begin
            tmr_d = tmr_q + 1'b1;
          end
          // Expiry wins over a coincident release; that release is consumed.
          if (hold_expire) begin
            long_d  = 1'b1;
            state_d = S_ARMED;
          end else if (rel_edge) begin
            short_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_ARMED: begin
          if (rel_edge) begin
            state_d = S_WINDOW;
            cnt_d   = '0;
            tmr_d   = '0;
          end
        end
        S_WINDOW: begin
          if (press_edge && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (tick) begin
            tmr_d = tmr_q + 1'b1;
          end
          if (win_expire) begin
            state_d = S_REPORT;
          end
        end
        S_REPORT: begin
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        tmr_q   <= '0;
        cnt_q   <= '0;
        rpt_q   <= '0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
        cnt_q   <= cnt_d;
        short_q <= short_d;
        long_q  <= long_d;
        valid_q <= valid_d;
        if (valid_d) begin
          rpt_q <= cnt_q;
        end
      end
    end

    assign btn_level[i]               = lvl_q;
    assign short_pulse[i]             = short_q;
    assign long_pulse[i]              = long_q;
    assign cnt_valid[i]               = valid_q;
    assign press_cnt[i*CNT_W +: CNT_W] = rpt_q;
  end

endmodule

// File: tb/tb_btn_gesture_multi.sv
module tb_btn_gesture_multi;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  btn_raw = 2'b11;

  logic [N-1:0]    btn_level, short_pulse, long_pulse, cnt_valid;
  logic [N*CW-1:0] press_cnt;
  logic [N-1:0]    sat_level, sat_short, sat_long, sat_valid;
  logic [N*CW-1:0] sat_cnt;

  always #5 clk = ~clk;

  btn_gesture_multi #(
    .N_BTN(N), .TICK_DIV(TD), .DEBOUNCE_TICKS(2), .LONG_TICKS(10),
    .WINDOW_TICKS(20), .CNT_W(CW), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .short_pulse(short_pulse), .long_pulse(long_pulse),
    .cnt_valid(cnt_valid), .press_cnt(press_cnt)
  );

  // Nine debounced presses cannot fit in a 20-tick window at this debounce
  // setting, so a second instance with a longer window covers saturation.
  btn_gesture_multi #(
    .N_BTN(N), .TICK_DIV(TD), .DEBOUNCE_TICKS(2), .LONG_TICKS(10),
    .WINDOW_TICKS(60), .CNT_W(CW), .ACTIVE_LOW(1)
  ) dut_sat (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(sat_level),
    .short_pulse(sat_short), .long_pulse(sat_long),
    .cnt_valid(sat_valid), .press_cnt(sat_cnt)
  );

  // Event monitor: counts high cycles of each pulse, so a stretched pulse
  // shows up as an extra count.
  int   cyc = 0;
  int   n_s0 = 0, n_s1 = 0, n_l0 = 0, n_l1 = 0, n_v0 = 0, n_v1 = 0;
  int   n_both = 0, n_hi1 = 0, n_sat_v0 = 0;
  int   rise_cyc0 = 0, long_cyc0 = 0;
  logic lvl0_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    lvl0_prev <= btn_level[0];
    if (!rst) begin
      if (short_pulse[0]) n_s0 <= n_s0 + 1;
      if (short_pulse[1]) n_s1 <= n_s1 + 1;
      if (long_pulse[0])  n_l0 <= n_l0 + 1;
      if (long_pulse[1])  n_l1 <= n_l1 + 1;
      if (cnt_valid[0])   n_v0 <= n_v0 + 1;
      if (cnt_valid[1])   n_v1 <= n_v1 + 1;
      if (short_pulse == 2'b11) n_both <= n_both + 1;
      if (btn_level[1])   n_hi1 <= n_hi1 + 1;
      if (sat_valid[0])   n_sat_v0 <= n_sat_v0 + 1;
      if (btn_level[0] && !lvl0_prev) rise_cyc0 <= cyc;
      if (long_pulse[0])  long_cyc0 <= cyc;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive-then-wait keeps every stimulus change on the same tick phase.
  task automatic step(input logic [1:0] press, input int ticks);
    btn_raw = ~press;
    repeat (ticks * TD) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_raw = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Expected counts are cumulative from the start of the table.
  typedef struct {
    logic [1:0] press;
    int         ticks;
    bit         chk;
    logic [1:0] lvl;
    int         s0, l0, v0, s1, l1, v1, both, hi1, cnt0, cnt1;
  } step_t;

  step_t steps[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_s0, b_s1, b_l0, b_v0, b_sat;

    // short press on ch0
    steps[0]  = '{2'b01,  5, 1'b1, 2'b01, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[1]  = '{2'b00,  6, 1'b1, 2'b00, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    // long press, then three presses in the window
    steps[2]  = '{2'b01, 12, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[3]  = '{2'b00,  3, 1'b1, 2'b00, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[4]  = '{2'b01,  3, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[5]  = '{2'b00,  3, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[6]  = '{2'b01,  3, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[7]  = '{2'b00,  3, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[8]  = '{2'b01,  3, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[9]  = '{2'b00, 12, 1'b1, 2'b00, 1, 1, 1, 0, 0, 0, 0,  0, 3, 0};
    // one-tick glitches on ch1
    steps[10] = '{2'b10,  1, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[11] = '{2'b00,  3, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[12] = '{2'b10,  1, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[13] = '{2'b00,  3, 1'b1, 2'b00, 1, 1, 1, 0, 0, 0, 0,  0, 3, 0};
    // simultaneous short presses; ch1 level high for exactly 5 ticks
    steps[14] = '{2'b11,  5, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    steps[15] = '{2'b00,  6, 1'b1, 2'b00, 2, 1, 1, 1, 0, 0, 1, 20, 3, 0};

    do_reset();
    check("reset_level",     int'(btn_level),   0);
    check("reset_short",     int'(short_pulse), 0);
    check("reset_long",      int'(long_pulse),  0);
    check("reset_valid",     int'(cnt_valid),   0);
    check("reset_cnt",       int'(press_cnt),   0);
    check("reset_sat_all",   int'({sat_level, sat_short, sat_long, sat_valid, sat_cnt}), 0);

    for (int i = 0; i < 16; i++) begin
      step(steps[i].press, steps[i].ticks);
      if (steps[i].chk) begin
        check($sformatf("t%0d_level", i), int'(btn_level), int'(steps[i].lvl));
        check($sformatf("t%0d_short0", i), n_s0, steps[i].s0);
        check($sformatf("t%0d_long0", i),  n_l0, steps[i].l0);
        check($sformatf("t%0d_valid0", i), n_v0, steps[i].v0);
        check($sformatf("t%0d_short1", i), n_s1, steps[i].s1);
        check($sformatf("t%0d_long1", i),  n_l1, steps[i].l1);
        check($sformatf("t%0d_valid1", i), n_v1, steps[i].v1);
        check($sformatf("t%0d_both", i),   n_both, steps[i].both);
        check($sformatf("t%0d_hi1", i),    n_hi1, steps[i].hi1);
        check($sformatf("t%0d_cnt0", i),   int'(press_cnt[2:0]), steps[i].cnt0);
        check($sformatf("t%0d_cnt1", i),   int'(press_cnt[5:3]), steps[i].cnt1);
      end
    end

    // Reset in WINDOW after two presses; press_cnt still holds 3 from above.
    step(2'b01, 12);
    step(2'b00, 3);
    step(2'b01, 3);
    step(2'b00, 3);
    step(2'b01, 3);
    step(2'b00, 2);
    rst = 1'b1;
    #1;
    check("rstmid_level", int'(btn_level),   0);
    check("rstmid_short", int'(short_pulse), 0);
    check("rstmid_long",  int'(long_pulse),  0);
    check("rstmid_valid", int'(cnt_valid),   0);
    check("rstmid_cnt",   int'(press_cnt),   0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    b_s0 = n_s0; b_l0 = n_l0; b_v0 = n_v0;
    step(2'b01, 5);
    step(2'b00, 6);
    step(2'b00, 25);
    check("post_rst_short", n_s0 - b_s0, 1);
    check("post_rst_long",  n_l0 - b_l0, 0);
    check("post_rst_valid", n_v0 - b_v0, 0);

    // Release exactly at hold expiry: long wins, release is consumed, so the
    // next release opens the window and only one press is counted.
    b_s0 = n_s0; b_l0 = n_l0; b_v0 = n_v0;
    step(2'b01, 10);
    step(2'b00, 4);
    check("expiry_long",    n_l0 - b_l0, 1);
    check("expiry_short",   n_s0 - b_s0, 0);
    check("long_latency",   long_cyc0 - rise_cyc0, 40);
    step(2'b01, 3);
    step(2'b00, 3);
    step(2'b01, 3);
    step(2'b00, 25);
    check("expiry_valid",   n_v0 - b_v0, 1);
    check("expiry_cnt",     int'(press_cnt[2:0]), 1);
    check("expiry_short2",  n_s0 - b_s0, 0);

    // Press landing on the window's last tick is counted; the button is still
    // held at close, so its release in IDLE gives nothing.
    b_s0 = n_s0; b_l0 = n_l0; b_v0 = n_v0;
    step(2'b01, 12);
    step(2'b00, 3);
    step(2'b01, 3);
    step(2'b00, 14);
    step(2'b01, 6);
    step(2'b00, 10);
    check("winend_long",  n_l0 - b_l0, 1);
    check("winend_valid", n_v0 - b_v0, 1);
    check("winend_cnt",   int'(press_cnt[2:0]), 2);
    check("winend_short", n_s0 - b_s0, 0);

    // Saturation: nine presses in the long window of dut_sat.
    do_reset();
    b_s0 = n_s0; b_v0 = n_v0; b_sat = n_sat_v0; b_s1 = n_s1;
    step(2'b01, 12);
    step(2'b00, 3);
    for (int k = 0; k < 9; k++) begin
      step(2'b01, 3);
      step(2'b00, 3);
    end
    step(2'b00, 50);
    check("sat_valid", n_sat_v0 - b_sat, 1);
    check("sat_cnt",   int'(sat_cnt[2:0]), 7);
    check("main_valid_during_sat", n_v0 - b_v0, 1);
    check("main_cnt_during_sat",   int'(press_cnt[2:0]), 3);
    check("main_short_after_win",  n_s0 - b_s0, 6);
    check("ch1_quiet",             n_s1 - b_s1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
